apb_slave_regfile: RTL



---
 rtl/apb_pkg.sv | 12 +
 rtl/apb_regfile_mem.sv | 30 +++
 rtl/apb_slave_regfile.sv | 99 +++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Definitions shared by the APB master and completer: bus widths and the
// completer FSM state encoding.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

endpackage

// File: rtl/apb_regfile_mem.sv
// DEPTH x DATA_W register storage: async clear, synchronous write port,
// combinational read port.
module apb_regfile_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: this storage is flops, not a RAM macro, so clearing every entry on
  // reset is legal and gives software a known all-zero register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with programmable wait states in front of a small register
// file; out-of-range addresses answer with pslverr.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int               ADDR_W      = APB_ADDR_W,
  parameter int               DATA_W      = APB_DATA_W,
  parameter int               DEPTH       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int               WAIT_CYCLES = 1
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]        state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_write;
  logic [DATA_W-1:0] lat_wdata;

  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;

  // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
  assign offset   = lat_addr - BASE_ADDR;
  assign in_range = offset < ADDR_W'(DEPTH);
  assign idx      = offset[IDX_W-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (psel && !penable) begin
            lat_addr  <= paddr;
            lat_write <= pwrite;
            lat_wdata <= pwdata;
            wait_cnt  <= 4'(WAIT_CYCLES);
            state     <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          if (!psel) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Completion (psel & penable) and abort (!psel) both end in IDLE.
          if (!psel || penable) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en = (state == ST_ACCESS) && psel && penable && in_range && lat_write;

  apb_regfile_mem #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (pclk),
    .rst  (preset),
    .we   (wr_en),
    .waddr(idx),
    .wdata(lat_wdata),
    .raddr(idx),
    .rdata(rd_data)
  );

  assign pready  = (state == ST_ACCESS);
  assign pslverr = pready && !in_range;
  assign prdata  = (pready && in_range && !lat_write) ? rd_data : '0;

endmodule
